// File: rtl/video_switch_pkg.sv
// Shared definitions for the video source switch: sequencer states,
// CPU register offsets and STATUS/CTRL bit positions.
package video_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_BLANK     = 2'd2
  } switchState_e;

  localparam logic [7:0] CTRL_OFS   = 8'd0;
  localparam logic [7:0] FRAMES_OFS = 8'd1;

  localparam int CTRL_OVR_BIT = 7;

  localparam int STAT_BUSY_BIT = 7;
  localparam int STAT_IRQ_BIT  = 6;
  localparam int STAT_ERR_BIT  = 5;
  localparam int STAT_OVR_BIT  = 4;

  function automatic logic [7:0] packStatus(
    input logic       busyBit,
    input logic       irqBit,
    input logic       errBit,
    input logic       ovrBit,
    input logic [2:0] activeSrc
  );
    logic [7:0] stat;
    stat                = 8'd0;
    stat[STAT_BUSY_BIT] = busyBit;
    stat[STAT_IRQ_BIT]  = irqBit;
    stat[STAT_ERR_BIT]  = errBit;
    stat[STAT_OVR_BIT]  = ovrBit;
    stat[2:0]           = activeSrc;
    return stat;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability chain; resets to the deasserted level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/video_source_switch.sv
// CPU-controlled video source selector. Source changes wait for a frame
// boundary on the old source, then blank the picture for BLANK_FRAMES frames.
module video_source_switch
  import video_switch_pkg::*;
#(
  parameter int         NUM_SOURCES    = 2,
  parameter int         COLOR_WIDTH    = 1,
  parameter logic [7:0] PORT_BASE      = 8'h84,
  parameter int         BLANK_FRAMES   = 1,
  parameter int         TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         port_id,
  input  logic                               write_strobe,
  input  logic                               read_strobe,
  input  logic [7:0]                         out_port,
  output logic [7:0]                         in_port,
  input  logic                               mode_switch,
  input  logic [NUM_SOURCES-1:0]             src_hsync,
  input  logic [NUM_SOURCES-1:0]             src_vsync,
  input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_r,
  input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_g,
  input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_b,
  output logic                               hsync,
  output logic                               vsync,
  output logic [COLOR_WIDTH-1:0]             r,
  output logic [COLOR_WIDTH-1:0]             g,
  output logic [COLOR_WIDTH-1:0]             b,
  output logic                               busy,
  output logic                               irq
);

  localparam int               TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       BLANK_LOAD   = 4'(BLANK_FRAMES);
  localparam logic [3:0]       NUM_SRC4     = 4'(NUM_SOURCES);
  localparam logic [7:0]       ADDR_CTRL    = PORT_BASE + CTRL_OFS;
  localparam logic [7:0]       ADDR_FRAMES  = PORT_BASE + FRAMES_OFS;

  switchState_e         state_r;
  switchState_e         stateNext_s;
  logic [2:0]           active_r;
  logic [2:0]           activeNext_s;
  logic [2:0]           request_r;
  logic [2:0]           effReq_s;
  logic                 override_r;
  logic                 err_r;
  logic [7:0]           frames_r;
  logic [TW-1:0]        timeoutCnt_r;
  logic [TW-1:0]        timeoutNext_s;
  logic [3:0]           blankCnt_r;
  logic [3:0]           blankNext_s;
  logic                 prevVsync_r;
  logic                 vsFall_s;
  logic                 irqSet_s;
  logic                 modeSync_s;
  logic                 ctrlWr_s;
  logic                 clrWr_s;
  logic                 reqValid_s;
  logic                 unusedCtrlBits_s;

  // Sources padded to eight so a 3-bit index is always in range.
  logic [7:0]             hsAll_s;
  logic [7:0]             vsAll_s;
  logic [COLOR_WIDTH-1:0] rAll_s [8];
  logic [COLOR_WIDTH-1:0] gAll_s [8];
  logic [COLOR_WIDTH-1:0] bAll_s [8];

  for (genvar k = 0; k < 8; k++) begin : g_pad
    if (k < NUM_SOURCES) begin : g_src
      assign hsAll_s[k] = src_hsync[k];
      assign vsAll_s[k] = src_vsync[k];
      assign rAll_s[k]  = src_r[k*COLOR_WIDTH +: COLOR_WIDTH];
      assign gAll_s[k]  = src_g[k*COLOR_WIDTH +: COLOR_WIDTH];
      assign bAll_s[k]  = src_b[k*COLOR_WIDTH +: COLOR_WIDTH];
    end else begin : g_none
      assign hsAll_s[k] = 1'b1;
      assign vsAll_s[k] = 1'b1;
      assign rAll_s[k]  = {COLOR_WIDTH{1'b0}};
      assign gAll_s[k]  = {COLOR_WIDTH{1'b0}};
      assign bAll_s[k]  = {COLOR_WIDTH{1'b0}};
    end
  end

  sync_2ff uModeSync (
    .clk   (clk),
    .reset (reset),
    .d     (mode_switch),
    .q     (modeSync_s)
  );

  assign ctrlWr_s         = write_strobe && (port_id == ADDR_CTRL);
  assign clrWr_s          = write_strobe && (port_id == ADDR_FRAMES);
  assign reqValid_s       = ({1'b0, out_port[2:0]} < NUM_SRC4);
  assign unusedCtrlBits_s = ^out_port[6:3];
  assign effReq_s         = override_r ? {2'b00, modeSync_s} : request_r;
  // Frame edges seen during a CPU read are deliberately dropped.
  assign vsFall_s         = prevVsync_r && !vsAll_s[active_r] && !read_strobe;

  // Switch sequencer next-state logic.
  always_comb begin
    stateNext_s   = state_r;
    activeNext_s  = active_r;
    timeoutNext_s = timeoutCnt_r;
    blankNext_s   = blankCnt_r;
    irqSet_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (effReq_s != active_r) begin
          stateNext_s   = ST_WAIT_EDGE;
          timeoutNext_s = {TW{1'b0}};
        end else begin
          stateNext_s   = ST_IDLE;
        end
      end
      ST_WAIT_EDGE: begin
        if (vsFall_s || (timeoutCnt_r == TIMEOUT_LAST)) begin
          activeNext_s = effReq_s;
          blankNext_s  = BLANK_LOAD;
          stateNext_s  = ST_BLANK;
        end else begin
          timeoutNext_s = timeoutCnt_r + TW'(1);
        end
      end
      ST_BLANK: begin
        if (vsFall_s) begin
          if (blankCnt_r <= 4'd1) begin
            blankNext_s = 4'd0;
            stateNext_s = ST_IDLE;
            irqSet_s    = 1'b1;
          end else begin
            blankNext_s = blankCnt_r - 4'd1;
          end
        end else begin
          blankNext_s = blankCnt_r;
        end
      end
      default: begin
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers, edge history and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      active_r     <= 3'd0;
      timeoutCnt_r <= {TW{1'b0}};
      blankCnt_r   <= 4'd0;
      prevVsync_r  <= 1'b1;
      busy         <= 1'b0;
      frames_r     <= 8'd0;
    end else begin
      state_r      <= stateNext_s;
      active_r     <= activeNext_s;
      timeoutCnt_r <= timeoutNext_s;
      blankCnt_r   <= blankNext_s;
      // On a commit this samples the new source, so its first edge is clean.
      prevVsync_r  <= vsAll_s[activeNext_s];
      busy         <= (stateNext_s != ST_IDLE);
      if (vsFall_s) begin
        frames_r <= frames_r + 8'd1;
      end
    end
  end

  // CPU-visible control: request, override, sticky err and irq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      request_r  <= 3'd0;
      override_r <= 1'b0;
      err_r      <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ctrlWr_s) begin
        override_r <= out_port[CTRL_OVR_BIT];
        if (reqValid_s) begin
          request_r <= out_port[2:0];
        end else begin
          err_r <= 1'b1;
        end
      end else if (clrWr_s) begin
        err_r <= 1'b0;
      end
      if (irqSet_s) begin
        irq <= 1'b1;
      end else if (clrWr_s) begin
        irq <= 1'b0;
      end
    end
  end

  // Registered video path, blanked while the new source settles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      r     <= {COLOR_WIDTH{1'b0}};
      g     <= {COLOR_WIDTH{1'b0}};
      b     <= {COLOR_WIDTH{1'b0}};
    end else begin
      hsync <= hsAll_s[activeNext_s];
      vsync <= vsAll_s[activeNext_s];
      if (stateNext_s == ST_BLANK) begin
        r <= {COLOR_WIDTH{1'b0}};
        g <= {COLOR_WIDTH{1'b0}};
        b <= {COLOR_WIDTH{1'b0}};
      end else begin
        r <= rAll_s[activeNext_s];
        g <= gAll_s[activeNext_s];
        b <= bAll_s[activeNext_s];
      end
    end
  end

  // CPU read mux.
  always_comb begin
    case (port_id)
      ADDR_CTRL:   in_port = packStatus(busy, irq, err_r, override_r, active_r);
      ADDR_FRAMES: in_port = frames_r;
      default:     in_port = 8'd0;
    endcase
  end

endmodule

// File: doc/video_source_switch.md
VIDEO_SOURCE_SWITCH -- requirements
Module: video_source_switch

Interface
REQ-001 SHALL have parameters:
- NUM_SOURCES, default 2: number of video sources, range 2..8.
- COLOR_WIDTH, default 1: bits per colour channel.
- PORT_BASE, default 8'h84: CPU port address of CTRL/STATUS; PORT_BASE+1 is FRAMES.
- BLANK_FRAMES, default 1: frames of forced black after a switch, range 1..15.
- TIMEOUT_CYCLES, default 2**20: cycles to wait for an old-source vsync before forcing the switch.
REQ-002 SHALL have ports:
- clk  in  1  system clock; the block uses one clock.
- reset  in  1  asynchronous, active-low reset.
- port_id  in  8  CPU port address.
- write_strobe  in  1  CPU write strobe.
- read_strobe  in  1  CPU read strobe.
- out_port  in  8  CPU write data.
- in_port  out  8  CPU read data, combinational from port_id.
- mode_switch  in  1  asynchronous board switch.
- src_hsync  in  NUM_SOURCES  per-source hsync, active-low.
- src_vsync  in  NUM_SOURCES  per-source vsync, active-low.
- src_r, src_g, src_b  in  NUM_SOURCES*COLOR_WIDTH  per-source colour; source k occupies bits [k*COLOR_WIDTH +: COLOR_WIDTH].
- hsync, vsync  out  1  selected sync, registered.
- r, g, b  out  COLOR_WIDTH  selected colour, registered.
- busy  out  1  high while a switch is in progress.
- irq  out  1  sticky switch-done interrupt.

Function
REQ-003 SHALL register all video outputs from the active source, with 1-cycle latency from src_* to the outputs.
REQ-004 SHALL decode CTRL writes when write_strobe is high and port_id==PORT_BASE:
- bit7 sets override.
- bits[2:0] set the requested source.
- A value >= NUM_SOURCES leaves the request unchanged and sets the sticky err bit.
REQ-005 SHALL clear irq and err on a write with port_id==PORT_BASE+1; the data is ignored.
REQ-006 SHALL return STATUS on reads at PORT_BASE: {busy, irq, err, override, 1'b0, active[2:0]}.
REQ-007 SHALL return FRAMES on reads at PORT_BASE+1: an 8-bit count of active-source vsync falling edges that wraps 255->0. in_port SHALL be 0 at any other address.
REQ-008 SHALL synchronise mode_switch through two flops. While override is set, the effective request SHALL be the synchronised switch (1 selects source 1, 0 selects source 0).
REQ-009 SHALL detect a vsync falling edge on the active source from a registered previous sample of that source's vsync.
REQ-010 SHALL implement a three-state FSM:
- IDLE: if request != active, go to WAIT_EDGE and clear the timeout counter.
- WAIT_EDGE: on a vsync falling edge, or when the timeout counter reaches TIMEOUT_CYCLES-1, set active := request, load the previous-vsync register from the new source's current vsync, load the blank counter with BLANK_FRAMES, and go to BLANK.
- BLANK: r/g/b SHALL be forced to 0; each new-source vsync falling edge decrements the counter; at 0, go to IDLE and set irq.
REQ-011 SHALL hold busy high in WAIT_EDGE and BLANK.
REQ-012 SHALL accept request changes in any state without aborting the current switch; any mismatch is serviced on the return to IDLE.
REQ-013 SHALL process CTRL writes but SHALL NOT count vsync edges while read_strobe is high.
REQ-014 SHALL give set priority over clear: an irq set and an irq-clear write in the same cycle leave irq=1.

Reset
REQ-015 SHALL, while reset is low, force:
- state=IDLE, active=0, request=0, override=0, err=0, irq=0, FRAMES=0, counters=0.
- hsync=1, vsync=1, r=g=b=0.
REQ-016 SHALL leave IDLE normally after reset deasserts mid-switch; no partial switch is resumed.

Structure
REQ-017 SHALL put the FSM state encoding, register offsets and STATUS bit positions in a shared package, video_switch_pkg.
REQ-018 SHALL instantiate one sub-module, sync_2ff, for mode_switch synchronisation. The source mux SHALL be inline.

Verification
REQ-019 Reset: assert reset low for 5 cycles -> hsync=vsync=1, rgb=0, STATUS reads 8'h00.
REQ-020 Switch: NUM_SOURCES=4, write 8'h02 to PORT_BASE -> busy=1; rgb forced 0 from the first source-0 vsync fall; outputs track source 2; after 1 further source-2 vsync fall, busy=0, irq=1, STATUS=8'h42.
REQ-021 Bad request: write 8'h05 with NUM_SOURCES=4 -> active unchanged, err=1; a write to PORT_BASE+1 clears err and irq.
REQ-022 Dead source: source 0 vsync held high, TIMEOUT_CYCLES=1000, request source 1 -> switch committed exactly 1000 cycles after entering WAIT_EDGE.
REQ-023 Override: write 8'h80, toggle mode_switch 0->1 -> the switch to source 1 begins 3 cycles later; STATUS bit4=1.
REQ-024 Frames: 256 vsync falls on the active source -> FRAMES reads 0; a change of request during BLANK is serviced by a second switch.
